// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the 4-pixel array: erase, expose, ramp conversion,
// bus turnaround, readout capture and valid/ready pixel streaming.
module pixel_frame_ctrl #(
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_CYCLES = 255,
  parameter int unsigned READ_SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       erase,
  output logic       expose,
  output logic       read,
  output logic [7:0] cnt_value,
  output logic       cnt_oe,
  input  logic [7:0] data1_in,
  input  logic [7:0] data2_in,
  input  logic [7:0] data3_in,
  input  logic [7:0] data4_in,
  output logic [7:0] pix_data,
  output logic [1:0] pix_idx,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONV,
    S_TURN, S_READ, S_SEND
  } state_t;

  localparam logic [15:0] ER_LAST = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EX_LAST = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] RD_LAST = 16'(READ_SETTLE - 1);

  state_t      state_q;
  logic [15:0] ph_q;
  logic [7:0]  cap_q [4];
  logic        erase_q, expose_q, read_q, oe_q;
  logic [7:0]  cnt_q, pix_data_q;
  logic [1:0]  pix_idx_q;
  logic [1:0]  idx_d;
  logic        valid_q, busy_q, done_q;

  assign idx_d = pix_idx_q + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      for (int i = 0; i < 4; i++) cap_q[i] <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      read_q     <= 1'b0;
      oe_q       <= 1'b0;
      cnt_q      <= '0;
      pix_data_q <= '0;
      pix_idx_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // start coinciding with frame_done belongs to the old frame
          if (start && !done_q) begin
            state_q <= S_ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            ph_q    <= '0;
          end
        end
        S_ERASE: begin
          if (ph_q == ER_LAST) begin
            state_q  <= S_EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            ph_q     <= '0;
          end else begin
            ph_q <= ph_q + 16'd1;
          end
        end
        S_EXPOSE: begin
          if (ph_q == EX_LAST) begin
            state_q  <= S_CONV;
            expose_q <= 1'b0;
            oe_q     <= 1'b1;
            cnt_q    <= '0;
            ph_q     <= '0;
          end else begin
            ph_q <= ph_q + 16'd1;
          end
        end
        S_CONV: begin
          if (cnt_q == 8'hFF) begin
            state_q <= S_TURN;
            oe_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_TURN: begin
          state_q <= S_READ;
          read_q  <= 1'b1;
          ph_q    <= '0;
        end
        S_READ: begin
          if (ph_q == RD_LAST) begin
            state_q    <= S_SEND;
            read_q     <= 1'b0;
            cap_q[0]   <= data1_in;
            cap_q[1]   <= data2_in;
            cap_q[2]   <= data3_in;
            cap_q[3]   <= data4_in;
            pix_data_q <= data1_in;
            pix_idx_q  <= 2'd0;
            valid_q    <= 1'b1;
            ph_q       <= '0;
          end else begin
            ph_q <= ph_q + 16'd1;
          end
        end
        S_SEND: begin
          if (pix_ready) begin
            if (pix_idx_q == 2'd3) begin
              state_q    <= S_IDLE;
              valid_q    <= 1'b0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              pix_idx_q  <= 2'd0;
              pix_data_q <= '0;
            end else begin
              pix_idx_q  <= idx_d;
              pix_data_q <= cap_q[idx_d];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign read       = read_q;
  assign cnt_oe     = oe_q;
  assign cnt_value  = cnt_q;
  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: cycle-offset timeline model plus a pixel
// queue model, two instances (default and boundary parameters).
module tb_pixel_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start_a, start_b, pix_ready;
  logic [7:0] d1, d2, d3, d4;

  logic       e_a, x_a, r_a, oe_a, pv_a, b_a, fd_a;
  logic [7:0] cv_a, pd_a;
  logic [1:0] pi_a;
  logic       e_b, x_b, r_b, oe_b, pv_b, b_b, fd_b;
  logic [7:0] cv_b, pd_b;
  logic [1:0] pi_b;

  pixel_frame_ctrl u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .erase(e_a), .expose(x_a), .read(r_a),
    .cnt_value(cv_a), .cnt_oe(oe_a),
    .data1_in(d1), .data2_in(d2), .data3_in(d3), .data4_in(d4),
    .pix_data(pd_a), .pix_idx(pi_a), .pix_valid(pv_a),
    .pix_ready(pix_ready), .busy(b_a), .frame_done(fd_a)
  );

  pixel_frame_ctrl #(
    .ERASE_CYCLES(1), .EXPOSE_CYCLES(3), .READ_SETTLE(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .erase(e_b), .expose(x_b), .read(r_b),
    .cnt_value(cv_b), .cnt_oe(oe_b),
    .data1_in(d1), .data2_in(d2), .data3_in(d3), .data4_in(d4),
    .pix_data(pd_b), .pix_idx(pi_b), .pix_valid(pv_b),
    .pix_ready(pix_ready), .busy(b_b), .frame_done(fd_b)
  );

  bit         sel;
  logic [14:0] ctl;
  logic [9:0]  pix;
  logic [2:0]  nact;

  always_comb begin
    ctl = sel ? {e_b, x_b, r_b, oe_b, cv_b, b_b, pv_b, fd_b}
              : {e_a, x_a, r_a, oe_a, cv_a, b_a, pv_a, fd_a};
    pix = sel ? {pi_b, pd_b} : {pi_a, pd_a};
    nact = sel ? 3'(e_b) + 3'(x_b) + 3'(r_b) + 3'(oe_b)
               : 3'(e_a) + 3'(x_a) + 3'(r_a) + 3'(oe_a);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [14:0] exp_ctl(
    input bit er, ex, rd, oe, input logic [7:0] cv,
    input bit bz, pv, fd);
    return {er, ex, rd, oe, cv, bz, pv, fd};
  endfunction

  task automatic drive_start(input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // mode 0: ready high, 1: scripted stalls, 2: random ready
  task automatic frame(input bit s, input int E, X, R, input int mode,
                       input int rst_at, input bit extra,
                       input logic [7:0] px [4]);
    int conv0, turn0, read0, send0, k, stall;
    bit ins, rdy;
    sel = s;
    conv0 = E + X; turn0 = conv0 + 256;
    read0 = turn0 + 1; send0 = read0 + R;
    k = 0; stall = 0;
    d1 = px[0]; d2 = px[1]; d3 = px[2]; d4 = px[3];
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    for (int t = 0; t < 4000; t++) begin
      ins = (t >= send0);
      chk("excl", 32'(nact <= 3'd1), 32'd1);
      if (ins && k == 4) begin
        chk("done", 32'(ctl), 32'(exp_ctl(0,0,0,0,8'd0,0,0,1)));
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        chk("post", 32'(ctl), 32'(exp_ctl(0,0,0,0,8'd0,0,0,0)));
        return;
      end
      chk("ctl", 32'(ctl), 32'(exp_ctl(t < E, t >= E && t < conv0,
          t >= read0 && t < send0, t >= conv0 && t < turn0,
          (t >= conv0 && t < turn0) ? 8'(t - conv0) : 8'd0,
          1'b1, ins, 1'b0)));
      if (ins) chk("pix", 32'(pix), 32'({2'(k), px[k]}));
      if (rst_at >= 0 && t == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_now", 32'({ctl, pix}), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'({ctl, pix}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", 32'({ctl, pix}), 32'd0);
        return;
      end
      rdy = 1'b1;
      if (mode == 1 && ((k == 1 && stall < 3) || (k == 3 && stall < 1)))
        rdy = 1'b0;
      if (mode == 2) rdy = 1'($urandom_range(0, 1));
      if (!ins) rdy = 1'($urandom_range(0, 1));
      pix_ready = rdy;
      if (ins && rdy) begin k++; stall = 0; end
      else if (ins) stall++;
      drive_start(extra && (t == E + 10 || t == send0));
      @(negedge clk);
    end
    chk("timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] px [4];

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    pix_ready = 1'b1; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 32'({ctl, pix}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle", 32'({ctl, pix}), 32'd0);

    px = '{8'h3C, 8'h3C, 8'hA0, 8'hA0};
    frame(0, 5, 255, 2, 0, -1, 0, px);

    for (int i = 0; i < 4; i++) px[i] = 8'($urandom);
    frame(0, 5, 255, 2, 1, -1, 0, px);

    for (int i = 0; i < 4; i++) px[i] = 8'($urandom);
    frame(0, 5, 255, 2, 0, -1, 1, px);
    repeat (3) begin
      @(negedge clk);
      chk("idle_after", 32'(ctl), 32'd0);
    end

    frame(0, 5, 255, 2, 0, 5 + 255 + 99, 0, px);
    for (int i = 0; i < 4; i++) px[i] = 8'($urandom);
    frame(0, 5, 255, 2, 2, -1, 0, px);

    px = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    frame(1, 1, 3, 1, 0, -1, 0, px);
    px = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    frame(1, 1, 3, 1, 2, -1, 0, px);
    for (int i = 0; i < 4; i++) px[i] = 8'($urandom);
    frame(1, 1, 3, 1, 1, -1, 1, px);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
